// File: rtl/seq_signed_divider.sv
// -----------------------------------------------------------------------------
// seq_signed_divider
//
// Purpose
//   Iterative signed restoring divider used by the multicycle CPU for DIV.
//   The datapath presents the operands and pulses start. The control FSM stalls
//   on busy until done. LO then takes the quotient and HI takes the remainder.
//   One quotient bit is produced per clock. Every output is registered, so there
//   is no combinational path from any input to any output.
//
// Optional feature
//   DIV_EARLY_EXIT_EN : when defined, an operation with a nonzero divisor whose
//                       dividend magnitude is below the divisor magnitude
//                       completes straight from accept. In that case the
//                       quotient is 0, the remainder is a, and the latency is
//                       1 cycle. Results are bit-identical with or without the
//                       macro; only the latency changes.
//
// Ports
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous, active-high; clears all state
//   a            in   WIDTH  dividend (two's complement), sampled on accept
//   b            in   WIDTH  divisor  (two's complement), sampled on accept
//   start        in   1      request; only honoured in IDLE
//   quotient     out  WIDTH  signed quotient, truncated toward zero
//   remainder    out  WIDTH  signed remainder, sign follows the dividend
//   done         out  1      one-cycle completion pulse
//   div_by_zero  out  1      divisor of the last accepted operation was zero
//   busy         out  1      high in every state except IDLE
// -----------------------------------------------------------------------------
module seq_signed_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             div_by_zero,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // The counter must hold WIDTH-1.
  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] rem_reg;       // partial remainder magnitude
  logic [WIDTH-1:0] dvd_reg;       // dividend magnitude, becomes quotient magnitude
  logic [WIDTH-1:0] dvs_reg;       // divisor magnitude
  logic             sign_q_reg;
  logic             sign_r_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             done_reg;
  logic             dbz_reg;
  logic             busy_reg;

  // ---------------------------------------------------------------------------
  // Operand magnitudes. These are treated as unsigned, so negating MIN_INT
  // yields exactly 2^(WIDTH-1) with no overflow.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             b_is_zero;
  logic             early_exit;

  assign a_mag     = a[WIDTH-1] ? -a : a;
  assign b_mag     = b[WIDTH-1] ? -b : b;
  assign b_is_zero = (b == '0);

`ifdef DIV_EARLY_EXIT_EN
  // |a| < |b| means the quotient is 0 and the remainder is a itself.
  // This also catches a == 0.
  assign early_exit = !b_is_zero && (a_mag < b_mag);
`else
  assign early_exit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // One restoring step.
  // {rem,dvd} is shifted left by one bit. The divisor is then trial-subtracted
  // using WIDTH+1 bits. Because the shifted value is always below 2*divisor,
  // bit WIDTH of the difference is exactly the borrow.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   shift_val;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] dvd_step;

  assign shift_val = {rem_reg, dvd_reg[WIDTH-1]};
  assign trial     = shift_val - {1'b0, dvs_reg};
  assign q_bit     = ~trial[WIDTH];
  assign rem_step  = q_bit ? trial[WIDTH-1:0] : shift_val[WIDTH-1:0];

  // The dividend register shifts left. The fresh quotient bit enters at the
  // bottom, so after WIDTH steps the register holds the quotient magnitude.
  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_dvd_shift
      assign dvd_step[gi] = dvd_reg[gi-1];
    end
  endgenerate
  assign dvd_step[0] = q_bit;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          // A zero divisor or the early-exit case goes straight to DONE.
          if (b_is_zero || early_exit) begin
            state_next = S_DONE;
          end else begin
            state_next = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (cnt_reg == '0) begin
          state_next = S_FIX;
        end
      end
      S_FIX:   state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      rem_reg       <= '0;
      dvd_reg       <= '0;
      dvs_reg       <= '0;
      sign_q_reg    <= 1'b0;
      sign_r_reg    <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      done_reg      <= 1'b0;
      dbz_reg       <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      // busy and done are registered copies of the upcoming state. This keeps
      // them glitch-free and aligned with the state register.
      busy_reg  <= (state_next != S_IDLE);
      done_reg  <= (state_next == S_DONE);

      case (state_reg)
        S_IDLE: begin
          if (start) begin
            dvd_reg    <= a_mag;
            dvs_reg    <= b_mag;
            rem_reg    <= '0;
            cnt_reg    <= CNT_INIT;
            sign_q_reg <= a[WIDTH-1] ^ b[WIDTH-1];
            sign_r_reg <= a[WIDTH-1];
            dbz_reg    <= b_is_zero;
            if (early_exit) begin
              quotient_reg  <= '0;
              remainder_reg <= a;
            end
          end
        end
        S_RUN: begin
          rem_reg <= rem_step;
          dvd_reg <= dvd_step;
          cnt_reg <= cnt_reg - CNT_ONE;
        end
        S_FIX: begin
          // For MIN_INT / -1, q_mag is 2^(WIDTH-1) and sign_q is 0, so the
          // result wraps to MIN_INT by construction.
          quotient_reg  <= sign_q_reg ? -dvd_reg : dvd_reg;
          remainder_reg <= sign_r_reg ? -rem_reg : rem_reg;
        end
        default: ;
      endcase
    end
  end

  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign done        = done_reg;
  assign div_by_zero = dbz_reg;
  assign busy        = busy_reg;

endmodule
